// File: rtl/axil_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO bank.
// Holds the per-channel register offsets (byte offsets inside a 16-byte
// channel window), the AXI response codes and a helper that expands the
// four write strobes into a 32-bit bit mask.
package axil_gpio_pkg;

  localparam logic [3:0] OFS_DATA_OUT = 4'h0;
  localparam logic [3:0] OFS_DATA_IN  = 4'h4;
  localparam logic [3:0] OFS_EDGE_STS = 4'h8;
  localparam logic [3:0] OFS_EDGE_EN  = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One bit of mask per data bit, set where the owning byte lane is enabled.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_gpio_bank_channel.sv
// One GPIO channel of the bank.
// Holds the DATA_OUT and EDGE_EN registers, the gpio_in synchroniser,
// the previous-sample flop used for rising-edge detection and the W1C
// EDGE_STS register. Register access comes from the AXI front end in the
// top level as a qualified write strobe plus a combinational read port.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   wr_en           write to this channel this cycle (already decoded)
//   wr_ofs          byte offset of the written register inside the window
//   wdata, wstrb    write data and byte enables
//   rd_ofs          byte offset of the register to present on rd_data
//   rd_data         zero-extended register value
//   gpio_in         asynchronous pin inputs
//   gpio_out        DATA_OUT register
//   irq_req         any enabled edge status bit set
module gpio_channel
  import axil_gpio_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_ofs,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic [3:0]        rd_ofs,
  output logic [31:0]       rd_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq_req
);

  logic [GPIO_W-1:0] data_out;
  logic [GPIO_W-1:0] edge_sts;
  logic [GPIO_W-1:0] edge_en;
  logic [GPIO_W-1:0] sync_ff [SYNC_STAGES];
  logic [GPIO_W-1:0] prev;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] clr;
  logic [GPIO_W-1:0] mask_w;
  logic [GPIO_W-1:0] wdata_w;
  logic [31:0]       mask;
  logic              unused_bits;

  // Bits of the bus above GPIO_W have no storage behind them.
  assign mask        = lane_mask(wstrb);
  assign mask_w      = mask[GPIO_W-1:0];
  assign wdata_w     = wdata[GPIO_W-1:0];
  assign unused_bits = ^{mask, wdata};

  assign rise = sync_ff[SYNC_STAGES-1] & ~prev;

  // W1C clear vector; only nonzero on a write to EDGE_STS.
  assign clr = (wr_en && (wr_ofs == OFS_EDGE_STS)) ? (wdata_w & mask_w) : '0;

  // Synchroniser chain and previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync_ff[SYNC_STAGES-1];
    end
  end

  // Edge status: the set term is applied after the clear, so a rise that
  // lands in the same cycle as a W1C of that bit keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) edge_sts <= '0;
    else     edge_sts <= (edge_sts & ~clr) | rise;
  end

  // Byte-lane merged updates of the two read/write registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      edge_en  <= '0;
    end else if (wr_en) begin
      case (wr_ofs)
        OFS_DATA_OUT: data_out <= (data_out & ~mask_w) | (wdata_w & mask_w);
        OFS_EDGE_EN:  edge_en  <= (edge_en  & ~mask_w) | (wdata_w & mask_w);
        default: ;
      endcase
    end
  end

  // Read port, zero-extended to the bus width.
  always_comb begin
    rd_data = '0;
    case (rd_ofs)
      OFS_DATA_OUT: rd_data[GPIO_W-1:0] = data_out;
      OFS_DATA_IN:  rd_data[GPIO_W-1:0] = sync_ff[SYNC_STAGES-1];
      OFS_EDGE_STS: rd_data[GPIO_W-1:0] = edge_sts;
      OFS_EDGE_EN:  rd_data[GPIO_W-1:0] = edge_en;
      default: ;
    endcase
  end

  assign gpio_out = data_out;
  assign irq_req  = |(edge_sts & edge_en);

endmodule

// File: rtl/axil_gpio_bank.sv
// AXI4-Lite slave exposing NUM_CH GPIO channels of GPIO_W bits each.
// Each channel occupies a 16-byte window (addr[ADDR_W-1:4] selects the
// channel, addr[3:2] the register). This level handles the AW/W/B and
// AR/R handshakes, address decode and the registered interrupt; the
// per-channel registers live in gpio_channel.
// Ports:
//   aclk, areset     clock and synchronous active-high reset
//   s_axil_aw*/w*/b* write address, data and response channels
//   s_axil_ar*/r*    read address and data channels
//   gpio_out         channel outputs, channel c at [c*GPIO_W +: GPIO_W]
//   gpio_in          asynchronous channel inputs, same packing
//   irq              level interrupt, OR of enabled edge status
module axil_gpio_bank
  import axil_gpio_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int GPIO_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W-1:0]        s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [ADDR_W-1:0]        s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [NUM_CH*GPIO_W-1:0] gpio_out,
  input  logic [NUM_CH*GPIO_W-1:0] gpio_in,
  output logic                     irq
);

  localparam int CH_W = ADDR_W - 4;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic              aw_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_held;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              irq_q;

  logic              aw_fire;
  logic              w_fire;
  logic              ar_fire;
  logic              do_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [CH_W-1:0]   wr_ch;
  logic [CH_W-1:0]   rd_ch;
  logic              wr_ok;
  logic              rd_ok;
  logic [NUM_CH-1:0] ch_wr_en;
  logic [NUM_CH-1:0] irq_vec;
  logic [31:0]       ch_rd [NUM_CH];
  logic [31:0]       rd_sel;
  logic              unused_addr;

  assign unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign s_axil_awready = !aw_held && !bvalid_q;
  assign s_axil_wready  = !w_held && !bvalid_q;
  assign s_axil_arready = !rvalid_q;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;

  // A write commits in the cycle both halves are available, whether each
  // half was captured earlier or is handshaking right now.
  assign do_write = (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_addr  = aw_held ? aw_addr_q : s_axil_awaddr;
  assign wr_data  = w_held  ? wdata_q   : s_axil_wdata;
  assign wr_strb  = w_held  ? wstrb_q   : s_axil_wstrb;

  assign wr_ch = wr_addr[ADDR_W-1:4];
  assign rd_ch = s_axil_araddr[ADDR_W-1:4];
  assign wr_ok = {1'b0, wr_ch} < NUM_CH_L;
  assign rd_ok = {1'b0, rd_ch} < NUM_CH_L;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr_en[c] = do_write && wr_ok && (wr_ch == CH_W'(c));

    gpio_channel #(
      .GPIO_W      (GPIO_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (aclk),
      .rst      (areset),
      .wr_en    (ch_wr_en[c]),
      .wr_ofs   ({wr_addr[3:2], 2'b00}),
      .wdata    (wr_data),
      .wstrb    (wr_strb),
      .rd_ofs   ({s_axil_araddr[3:2], 2'b00}),
      .rd_data  (ch_rd[c]),
      .gpio_in  (gpio_in[c*GPIO_W +: GPIO_W]),
      .gpio_out (gpio_out[c*GPIO_W +: GPIO_W]),
      .irq_req  (irq_vec[c])
    );
  end

  // Channel read mux; out-of-range channels fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) rd_sel = ch_rd[c];
    end
  end

  // Write channel: AW and W are captured independently, the response is
  // raised the cycle after the register update and held until bready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (do_write) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axil_awaddr;
        end
        if (w_fire) begin
          w_held  <= 1'b1;
          wdata_q <= s_axil_wdata;
          wstrb_q <= s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: data is captured at the AR handshake and held until
  // the master takes it; arready stays low while a response is pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_ok ? rd_sel : '0;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Registered interrupt so irq is glitch-free at the pin.
  always_ff @(posedge aclk) begin
    if (areset) irq_q <= 1'b0;
    else        irq_q <= |irq_vec;
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_axil_gpio_bank.sv
// Directed testbench for axil_gpio_bank with NUM_CH=2, GPIO_W=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
module tb_axil_gpio_bank;

  localparam int NUM_CH      = 2;
  localparam int GPIO_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axil_gpio_bank #(
    .NUM_CH      (NUM_CH),
    .GPIO_W      (GPIO_W),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .gpio_out       (gpio_out),
    .gpio_in        (gpio_in),
    .irq            (irq)
  );

  // Wait (bounded) for ready: 0=aw, 1=w, 2=aw and w, 3=ar. Returns 1 time
  // unit after the handshake edge.
  task automatic wait_ready(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge aclk);
      case (which)
        0:       ok = awready;
        1:       ok = wready;
        2:       ok = awready && wready;
        default: ok = arready;
      endcase
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("[TB] FAIL handshake_timeout chan=%0d ready=0 required=1", which);
    end
    @(posedge aclk); #1;
  endtask

  task automatic get_b(output logic [1:0] resp);
    bit seen;
    seen  = 1'b0;
    resp  = 2'b11;
    bready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      if (bvalid) begin
        seen = 1'b1;
        resp = bresp;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("[TB] FAIL bvalid_timeout bvalid=0 required=1");
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // w_lead=0: AW and W together; w_lead>0: W presented that many cycles
  // before AW.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           output logic [1:0] resp);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (w_lead == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      wait_ready(2);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else begin
      wvalid = 1'b1;
      wait_ready(1);
      wvalid = 1'b0;
      repeat (w_lead) begin @(posedge aclk); #1; end
      awvalid = 1'b1;
      wait_ready(0);
      awvalid = 1'b0;
    end
    get_b(resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit seen;
    seen    = 1'b0;
    data    = 32'hDEAD_BEEF;
    resp    = 2'b11;
    araddr  = addr;
    arvalid = 1'b1;
    wait_ready(3);
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge aclk);
      if (rvalid) begin
        seen = 1'b1;
        data = rdata;
        resp = rresp;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("[TB] FAIL rvalid_timeout rvalid=0 required=1");
    end
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    areset  = 1'b1;
    awaddr  = '0; awvalid = 1'b0;
    wdata   = '0; wstrb   = '0; wvalid = 1'b0;
    bready  = 1'b0;
    araddr  = '0; arvalid = 1'b0; rready = 1'b0;
    gpio_in = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b required=111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, irq} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_valid_irq got=%b required=000", {bvalid, rvalid, irq});
    end
    checks++;
    if ({bresp, rresp, rdata, gpio_out} !== 68'd0) begin
      errors++;
      $display("[TB] FAIL reset_data bresp=%0h rresp=%0h rdata=%h gpio_out=%h required all 0",
               bresp, rresp, rdata, gpio_out);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_data_out();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(8'h00, 32'h0000_0055, 4'hF, 0, r);
    axi_write(8'h00, 32'h0000_00AA, 4'hF, 0, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL data_out_bresp got=%b required=00", r);
    end
    checks++;
    if (gpio_out[15:0] !== 16'h00AA) begin
      errors++;
      $display("[TB] FAIL data_out_pins got=%h required=00aa", gpio_out[15:0]);
    end
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'h0000_00AA || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL data_out_readback got=%h/%b required=000000aa/00", d, r);
    end
  endtask

  task automatic test_aw_first();
    logic [1:0]  r;
    logic [31:0] d;
    awaddr  = 8'h10;
    awvalid = 1'b1;
    wait_ready(0);
    awvalid = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    @(negedge aclk);
    checks++;
    if (gpio_out[31:16] !== 16'h0000 || bvalid !== 1'b0 || awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aw_held_state pins=%h bvalid=%b awready=%b required=0000/0/0",
               gpio_out[31:16], bvalid, awready);
    end
    @(posedge aclk); #1;
    wdata  = 32'h0000_1234;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    wait_ready(1);
    wvalid = 1'b0;
    get_b(r);
    @(negedge aclk);
    checks++;
    if (gpio_out[31:16] !== 16'h1234 || r !== 2'b00 || bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aw_first_write pins=%h bresp=%b bvalid_after=%b required=1234/00/0",
               gpio_out[31:16], r, bvalid);
    end
    @(posedge aclk); #1;
    axi_write(8'h10, 32'h0000_00FF, 4'b0001, 0, r);
    checks++;
    if (gpio_out[31:16] !== 16'h12FF) begin
      errors++;
      $display("[TB] FAIL byte_strobe got=%h required=12ff", gpio_out[31:16]);
    end
    axi_write(8'h10, 32'hFFFF_FFFF, 4'hF, 2, r);
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'h0000_FFFF || gpio_out[31:16] !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL w_first_upper_bits rdata=%h pins=%h required=0000ffff/ffff",
               d, gpio_out[31:16]);
    end
  endtask

  task automatic test_data_in();
    logic [1:0]  r;
    logic [31:0] d;
    gpio_in[15:0] = 16'h0044;
    repeat (4) begin @(posedge aclk); #1; end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000_0044) begin
      errors++;
      $display("[TB] FAIL data_in_44 got=%h required=00000044", d);
    end
    gpio_in[15:0] = 16'h00BB;
    repeat (4) begin @(posedge aclk); #1; end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000_00BB) begin
      errors++;
      $display("[TB] FAIL data_in_bb got=%h required=000000bb", d);
    end
    // AR handshake two edges after the pin change still sees the old value.
    gpio_in[15:0] = 16'h005A;
    @(posedge aclk); #1;
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000_00BB) begin
      errors++;
      $display("[TB] FAIL sync_latency_early got=%h required=000000bb", d);
    end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000_005A) begin
      errors++;
      $display("[TB] FAIL sync_latency_late got=%h required=0000005a", d);
    end
    axi_write(8'h04, 32'h0000_1234, 4'hF, 0, r);
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000_005A || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL data_in_readonly got=%h/%b required=0000005a/00", d, r);
    end
  endtask

  task automatic test_edge_irq();
    logic [1:0]  r;
    logic [31:0] d;
    gpio_in[15:0] = 16'h0000;
    repeat (6) begin @(posedge aclk); #1; end
    axi_write(8'h08, 32'h0000_FFFF, 4'hF, 0, r);
    axi_write(8'h0C, 32'h0000_00FF, 4'hF, 0, r);
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_cleared sts=%h irq=%b required=00000000/0", d, irq);
    end
    gpio_in[15:0] = 16'h0001;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_early got=%b required=0", irq);
    end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_assert got=%b required=1", irq);
    end
    @(posedge aclk); #1;
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL edge_sts_set got=%h required=00000001", d);
    end
    axi_write(8'h08, 32'h0000_0001, 4'hF, 0, r);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_clear got=%b required=0", irq);
    end
    // Bit 1 rises in the very cycle its W1C write commits.
    gpio_in[15:0] = 16'h0003;
    repeat (2) begin @(posedge aclk); #1; end
    axi_write(8'h08, 32'h0000_0002, 4'b0001, 0, r);
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h0000_0002 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins sts=%h irq=%b required=00000002/1", d, irq);
    end
    axi_write(8'h08, 32'h0000_0002, 4'b0001, 0, r);
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w1c_later sts=%h irq=%b required=00000000/0", d, irq);
    end
  endtask

  task automatic test_decode_err();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(8'h20, 32'h0000_FFFF, 4'hF, 0, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL decode_bresp got=%b required=10", r);
    end
    checks++;
    if (gpio_out !== 32'hFFFF_00AA) begin
      errors++;
      $display("[TB] FAIL decode_no_effect got=%h required=ffff00aa", gpio_out);
    end
    axi_read(8'h20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL decode_read got=%h/%b required=00000000/10", d, r);
    end
    axi_read(8'h3C, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL decode_read_hi got=%h/%b required=00000000/10", d, r);
    end
  endtask

  task automatic test_reset_mid();
    int b_seen;
    awaddr  = 8'h00;
    awvalid = 1'b1;
    wait_ready(0);
    awvalid = 1'b0;
    areset  = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b111000 || gpio_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs flags=%b gpio_out=%h required=111000/00000000",
               {awready, wready, arready, bvalid, rvalid, irq}, gpio_out);
    end
    @(posedge aclk); #1;
    wdata  = 32'h0000_FFFF;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    wait_ready(1);
    wvalid = 1'b0;
    b_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (bvalid) b_seen++;
    end
    checks++;
    if (b_seen != 0 || gpio_out !== 32'h0 || wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_b bvalid_cycles=%0d gpio_out=%h wready=%b required=0/00000000/0",
               b_seen, gpio_out, wready);
    end
  endtask

  initial begin
    test_reset();
    test_data_out();
    test_aw_first();
    test_data_in();
    test_edge_irq();
    test_decode_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
